// File: rtl/traffic_pkg.sv
// Shared light encodings, per-axis demand FSM states and wait-counter width
// for the intersection demand arbiter.
package traffic_pkg;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALL  = 2'd1,
        ST_SERVE = 2'd2
    } axis_state_e;

endpackage

// File: rtl/sec_tick_gen.sv
// One-cycle enable once every CLK_FREQ cycles; first pulse sampled at edge
// CLK_FREQ after reset.
module sec_tick_gen #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(CLK_FREQ - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_demand_arbiter.sv
// Debounces detectors, latches ped buttons into one call per axis (0 = NS,
// 1 = EW), clears calls on observed green and tracks per-axis wait seconds.
module traffic_demand_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned       N_DET    = 4,
    parameter int unsigned       DEB_CYC  = 16,
    parameter int unsigned       CLK_FREQ = 100_000_000,
    parameter logic [WAIT_W-1:0] MAX_WAIT = 8'd120
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DET-1:0]  det_ns,
    input  logic [N_DET-1:0]  det_ew,
    input  logic              ped_ns,
    input  logic              ped_ew,
    input  logic [2:0]        NS_str,
    input  logic [2:0]        EW_str,
    output logic              ns,
    output logic              ew,
    output logic [WAIT_W-1:0] ns_wait,
    output logic [WAIT_W-1:0] ew_wait,
    output logic              starve
);

    localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);

    logic                   tick;
    logic [1:0][N_DET-1:0]  det_c;
    logic [1:0][N_DET-1:0]  det_ev_c;
    logic [1:0]             ped_c;
    logic [1:0]             ev_c;
    logic [1:0]             green_c;

    axis_state_e            state_q [2];
    axis_state_e            state_d [2];
    logic [WAIT_W-1:0]      wait_q  [2];
    logic [WAIT_W-1:0]      wait_d  [2];
    logic [1:0]             call_q;
    logic [1:0]             call_d;
    logic                   starve_q;
    logic                   starve_d;

    sec_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign det_c   = {det_ew, det_ns};
    assign ped_c   = {ped_ew, ped_ns};
    assign green_c = {(EW_str == LIGHT_G), (NS_str == LIGHT_G)};

    // Per-bit debounce: one event per high run, on the DEB_CYC-th high sample.
    for (genvar a = 0; a < 2; a++) begin : g_axis
        for (genvar d = 0; d < int'(N_DET); d++) begin : g_det
            logic [DEB_W-1:0] cnt_q;
            logic [DEB_W-1:0] cnt_d;

            always_comb begin
                cnt_d = '0;
                if (det_c[a][d]) begin
                    cnt_d = (cnt_q == DEB_W'(DEB_CYC)) ? cnt_q : cnt_q + DEB_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign det_ev_c[a][d] = det_c[a][d] && (cnt_q == DEB_W'(DEB_CYC - 1));
        end

        assign ev_c[a] = (|det_ev_c[a]) | ped_c[a];
    end

    // Axis FSMs; green always wins over a simultaneous event.
    always_comb begin
        starve_d = 1'b0;
        for (int a = 0; a < 2; a++) begin
            state_d[a] = state_q[a];
            wait_d[a]  = '0;
            call_d[a]  = 1'b0;

            case (state_q[a])
                ST_IDLE: begin
                    if (green_c[a]) begin
                        state_d[a] = ST_SERVE;
                    end else if (ev_c[a]) begin
                        state_d[a] = ST_CALL;
                    end
                end
                ST_CALL: begin
                    if (green_c[a]) begin
                        state_d[a] = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (!green_c[a]) begin
                        state_d[a] = ev_c[a] ? ST_CALL : ST_IDLE;
                    end
                end
                default: begin
                    state_d[a] = ST_IDLE;
                end
            endcase

            // Wait restarts from zero on every entry into CALL.
            if ((state_d[a] == ST_CALL) && (state_q[a] == ST_CALL)) begin
                wait_d[a] = wait_q[a];
                if (tick && (wait_q[a] != {WAIT_W{1'b1}})) begin
                    wait_d[a] = wait_q[a] + WAIT_W'(1);
                end
            end

            call_d[a] = (state_d[a] == ST_CALL);
            if (wait_q[a] >= MAX_WAIT) begin
                starve_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 2; a++) begin
                state_q[a] <= ST_IDLE;
                wait_q[a]  <= '0;
            end
            call_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                state_q[a] <= state_d[a];
                wait_q[a]  <= wait_d[a];
            end
            call_q   <= call_d;
            starve_q <= starve_d;
        end
    end

    assign ns      = call_q[0];
    assign ew      = call_q[1];
    assign ns_wait = wait_q[0];
    assign ew_wait = wait_q[1];
    assign starve  = starve_q;

endmodule

// File: tb/tb_traffic_demand_arbiter.sv
// Directed bench for traffic_demand_arbiter with DEB_CYC=4, CLK_FREQ=10,
// MAX_WAIT=3; edge numbers in comments count from the last reset edge.
module tb_traffic_demand_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] det_ns;
    logic [3:0] det_ew;
    logic       ped_ns;
    logic       ped_ew;
    logic [2:0] NS_str;
    logic [2:0] EW_str;
    logic       ns;
    logic       ew;
    logic [7:0] ns_wait;
    logic [7:0] ew_wait;
    logic       starve;

    int n_checks = 0;
    int n_fails  = 0;

    traffic_demand_arbiter #(
        .N_DET    (4),
        .DEB_CYC  (4),
        .CLK_FREQ (10),
        .MAX_WAIT (8'd3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .det_ns  (det_ns),
        .det_ew  (det_ew),
        .ped_ns  (ped_ns),
        .ped_ew  (ped_ew),
        .NS_str  (NS_str),
        .EW_str  (EW_str),
        .ns      (ns),
        .ew      (ew),
        .ns_wait (ns_wait),
        .ew_wait (ew_wait),
        .starve  (starve)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        det_ns = '0;
        det_ew = '0;
        ped_ns = 1'b0;
        ped_ew = 1'b0;
        NS_str = 3'b100;
        EW_str = 3'b100;
        step(2);
        rst = 1'b0;
        // edge 0
        check("rst_ns", 8'(ns), 8'd0);
        check("rst_ew", 8'(ew), 8'd0);
        check("rst_ns_wait", ns_wait, 8'd0);
        check("rst_ew_wait", ew_wait, 8'd0);
        check("rst_starve", 8'(starve), 8'd0);

        // Short glitch: 3 high samples do not qualify
        det_ns = 4'b0001;
        step(3);                                    // edge 3
        check("glitch_3hi", 8'(ns), 8'd0);
        det_ns = 4'b0000;
        step(1);                                    // edge 4
        check("glitch_low", 8'(ns), 8'd0);

        // Four high samples qualify on the 4th edge
        det_ns = 4'b0001;
        step(3);                                    // edge 7
        check("deb_3of4", 8'(ns), 8'd0);
        step(1);                                    // edge 8
        check("deb_4of4", 8'(ns), 8'd1);
        check("deb_wait0", ns_wait, 8'd0);
        step(2);                                    // edge 10, first tick
        check("ns_wait_tick1", ns_wait, 8'd1);

        // Serve while detector stays high; no second event after green ends
        NS_str = 3'b001;
        step(1);                                    // edge 11
        check("serve_ns", 8'(ns), 8'd0);
        check("serve_ns_wait", ns_wait, 8'd0);
        step(3);                                    // edge 14
        NS_str = 3'b100;
        step(1);                                    // edge 15
        check("post_green_no_ev", 8'(ns), 8'd0);
        step(10);                                   // edge 25, 21 high samples
        check("long_high_one_ev", 8'(ns), 8'd0);
        det_ns = 4'b0000;

        // Ped pulse, wait counting and starvation
        ped_ew = 1'b1;
        step(1);                                    // edge 26
        ped_ew = 1'b0;
        check("ped_ew_call", 8'(ew), 8'd1);
        check("ped_ew_wait0", ew_wait, 8'd0);
        step(4);                                    // edge 30
        check("ew_wait_1", ew_wait, 8'd1);
        step(9);                                    // edge 39
        check("ew_wait_hold1", ew_wait, 8'd1);
        step(1);                                    // edge 40
        check("ew_wait_2", ew_wait, 8'd2);
        step(10);                                   // edge 50
        check("ew_wait_3", ew_wait, 8'd3);
        check("starve_lag", 8'(starve), 8'd0);
        step(1);                                    // edge 51
        check("starve_set", 8'(starve), 8'd1);
        EW_str = 3'b001;
        step(1);                                    // edge 52
        check("serve_ew", 8'(ew), 8'd0);
        check("serve_ew_wait", ew_wait, 8'd0);
        step(1);                                    // edge 53
        check("starve_clr", 8'(starve), 8'd0);
        EW_str = 3'b100;
        step(1);                                    // edge 54

        // Serve and clear; ped during green ignored; ped as green ends re-calls
        ped_ns = 1'b1;
        step(1);                                    // edge 55
        ped_ns = 1'b0;
        check("ped_ns_call", 8'(ns), 8'd1);
        step(5);                                    // edge 60
        check("ns_wait_1", ns_wait, 8'd1);
        NS_str = 3'b001;
        step(1);                                    // edge 61
        check("green_clr_ns", 8'(ns), 8'd0);
        check("green_clr_wait", ns_wait, 8'd0);
        ped_ns = 1'b1;
        step(1);                                    // edge 62
        ped_ns = 1'b0;
        check("ped_in_green", 8'(ns), 8'd0);
        step(1);                                    // edge 63
        NS_str = 3'b010;
        ped_ns = 1'b1;
        step(1);                                    // edge 64
        ped_ns = 1'b0;
        check("ped_at_green_end", 8'(ns), 8'd1);
        check("recall_wait0", ns_wait, 8'd0);
        NS_str = 3'b001;
        step(1);                                    // edge 65
        NS_str = 3'b100;
        step(1);                                    // edge 66

        // Event and green together from IDLE: green wins
        ped_ns = 1'b1;
        NS_str = 3'b001;
        step(1);                                    // edge 67
        ped_ns = 1'b0;
        check("simul_serve", 8'(ns), 8'd0);
        NS_str = 3'b100;
        step(1);                                    // edge 68
        check("simul_idle", 8'(ns), 8'd0);

        // Non-one-hot 011 is not green
        ped_ns = 1'b1;
        step(1);                                    // edge 69
        ped_ns = 1'b0;
        check("illegal_pre", 8'(ns), 8'd1);
        NS_str = 3'b011;
        step(2);                                    // edge 71
        check("illegal_not_green", 8'(ns), 8'd1);
        NS_str = 3'b001;
        step(1);                                    // edge 72
        check("legal_green", 8'(ns), 8'd0);
        NS_str = 3'b100;
        step(1);                                    // edge 73

        // Saturation: EW call held past 300 s
        ped_ew = 1'b1;
        step(1);                                    // edge 74
        ped_ew = 1'b0;
        check("sat_call", 8'(ew), 8'd1);
        step(2545);                                 // edge 2619
        check("sat_254", ew_wait, 8'd254);
        step(1);                                    // edge 2620
        check("sat_255", ew_wait, 8'd255);
        step(454);                                  // edge 3074
        check("sat_hold", ew_wait, 8'd255);
        check("sat_ew", 8'(ew), 8'd1);
        check("sat_starve", 8'(starve), 8'd1);

        // Reset mid-call and mid-debounce
        det_ew = 4'b0001;
        step(2);                                    // edge 3076, count at 2
        rst = 1'b1;
        step(1);                                    // reset edge
        rst = 1'b0;
        check("mrst_ns", 8'(ns), 8'd0);
        check("mrst_ew", 8'(ew), 8'd0);
        check("mrst_ns_wait", ns_wait, 8'd0);
        check("mrst_ew_wait", ew_wait, 8'd0);
        check("mrst_starve", 8'(starve), 8'd0);
        step(3);
        check("requal_3", 8'(ew), 8'd0);
        step(1);
        check("requal_4", 8'(ew), 8'd1);
        check("requal_wait", ew_wait, 8'd0);
        det_ew = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/traffic_demand_arbiter.md
# traffic_demand_arbiter

Sequences demand into the intersection light controller. It debounces per-approach vehicle detectors and latches pedestrian buttons into one pending call per axis (NS, EW). It drives the controller's `ns`/`ew` demand inputs, and clears each call when the observed straight-green light serves that axis. It also tracks per-axis wait time in seconds and flags starvation.

## Interface
- `N_DET`, 4 — detectors per axis.
- `DEB_CYC`, 16 — consecutive high cycles needed to qualify a detector (≥2).
- `CLK_FREQ`, 100_000_000 — clk cycles per second tick.
- `MAX_WAIT`, 8'd120 — wait seconds at or above which `starve` asserts.

Ports:
- `clk`  in  1  — clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `det_ns`  in  N_DET  — raw NS detectors, already synchronized to clk.
- `det_ew`  in  N_DET  — raw EW detectors, already synchronized to clk.
- `ped_ns`  in  1  — NS pedestrian request, single-cycle pulse, no debounce.
- `ped_ew`  in  1  — EW pedestrian request, single-cycle pulse, no debounce.
- `NS_str`  in  3  — observed NS straight light; one-hot R=100, Y=010, G=001.
- `EW_str`  in  3  — observed EW straight light; same encoding.
- `ns`  out  1  — NS call pending, to the light controller.
- `ew`  out  1  — EW call pending, to the light controller.
- `ns_wait`  out  8  — seconds the NS call has been pending, saturating.
- `ew_wait`  out  8  — seconds the EW call has been pending, saturating.
- `starve`  out  1  — registered; high when either wait ≥ MAX_WAIT.

## Operation
- **Debounce, per detector bit:**
  - Counter width $clog2(DEB_CYC+1).
  - Increments while the bit is high, saturating at DEB_CYC; cleared to 0 on any low cycle.
  - Event fires when the counter is at DEB_CYC−1 and the bit is high, so one event per high run.
- **Axis event:** OR of that axis's detector events and its ped pulse.
- **Axis green:** `*_str == 3'b001` exactly. Any non-one-hot code counts as not green.
- **Per-axis FSM:**
  - IDLE → CALL on event while not green.
  - IDLE → SERVE on green.
  - CALL → SERVE on green.
  - SERVE → CALL when green ends with an event in the same cycle.
  - SERVE → IDLE when green ends with no event.
  - Events during SERVE are discarded, since the vehicle is being served.
- **Simultaneous event and green:** green wins.
- **Call outputs:** `ns`/`ew` = (axis state == CALL), registered.
- **Wait counters:**
  - Cleared on every transition into CALL, and held at 0 in IDLE and SERVE.
  - In CALL, increment on the second tick and saturate at 255.
- **Starvation:** `starve` is registered one cycle after the compare.
- **Reset:**
  - FSMs go to IDLE; debounce counters, wait counters and the prescaler clear.
  - `ns`=`ew`=0, `ns_wait`=`ew_wait`=0, `starve`=0.
  - A mid-call reset drops all calls.

## Timing
- **Detector path:** bit sampled high at edges 1..DEB_CYC gives CALL and `ns`/`ew`=1 after edge DEB_CYC.
- **Ped path:** pulse sampled at edge k gives call high after edge k.
- **Green observed at edge k:** call low after edge k; wait reads 0 after edge k.
- **Second tick:** the prescaler counts 0..CLK_FREQ−1 and pulses for one cycle when the count equals CLK_FREQ−1. The first tick after reset occurs at edge CLK_FREQ.
- **Wait timing:** the wait counter updates on the same edge as the tick. `starve` follows one edge later.

## Structure
- **Package `traffic_pkg`:**
  - Light encodings R/Y/G.
  - Axis FSM state typedef (IDLE, CALL, SERVE).
  - Width constant 8 for wait counters.
- **Sub-module `sec_tick_gen`:** parameter CLK_FREQ; ports clk, rst, tick. Shared with the light controller's one-second enable. Two instances, one per axis, of generate-loop debounce logic; no further sub-modules.

## Test plan
All scenarios use DEB_CYC=4, CLK_FREQ=10, MAX_WAIT=3.
1. **Short glitch:** `det_ns[0]` high 3 cycles, then low → `ns` stays 0.
   - Held high 4 cycles → `ns`=1 after the 4th edge.
   - Held high 20 cycles → still exactly one event.
2. **Ped pulse and wait:** `ped_ew` 1-cycle pulse with `EW_str`=100 → `ew`=1 next edge.
   - `ew_wait` then increments every 10 cycles.
   - `starve`=1 one edge after `ew_wait` reaches 3.
3. **Serve and clear:** pending `ns`, then `NS_str`=001 → `ns`=0 and `ns_wait`=0 next edge.
   - `ped_ns` during green → ignored.
   - `ped_ns` in the same cycle green drops to 010 → `ns`=1.
4. **Simultaneous event and green:** event and green arrive together from IDLE → SERVE, `ns`=0.
   - Illegal code `NS_str`=011 is treated as not green, so the call stays pending.
5. **Saturation:** call held 300 s with no green → wait stays at 255, no wrap.
6. **Reset mid-operation:** `rst` pulsed mid-call and mid-debounce.
   - All outputs are 0 next edge.
   - A detector still high needs a full 4 fresh cycles to re-qualify.
